// File: rtl/wb_cmd_bridge.sv
// Wishbone slave bridging management-core register accesses to a buffered
// 32-bit command stream and a buffered 32-bit response stream.
module wb_cmd_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] cmd_data_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    input  logic [31:0] rsp_data_i,
    input  logic        rsp_valid_i,
    output logic        rsp_ready_o,
    output logic        irq_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        REG_CMD    = 2'd0,
        REG_STATUS = 2'd1,
        REG_RESP   = 2'd2,
        REG_CTRL   = 2'd3
    } reg_e;

    // Bus-side decode
    logic        ack_q;
    logic [31:0] dat_q;
    logic        hit;
    logic        wr_ok;
    logic        rd_hit;
    reg_e        reg_sel;
    logic        unused_adr;

    assign hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~ack_q;
    assign reg_sel    = reg_e'(wbs_adr_i[3:2]);
    assign wr_ok      = hit & wbs_we_i & (wbs_sel_i == 4'hF);
    assign rd_hit     = hit & ~wbs_we_i;
    assign unused_adr = ^wbs_adr_i[1:0];

    logic cmd_push_req;
    logic ctrl_wr;
    logic flush;
    logic flag_clr;
    logic resp_rd;

    assign cmd_push_req = wr_ok & (reg_sel == REG_CMD);
    assign ctrl_wr      = wr_ok & (reg_sel == REG_CTRL);
    assign flush        = ctrl_wr & wbs_dat_i[0];
    assign flag_clr     = ctrl_wr & wbs_dat_i[1];
    assign resp_rd      = rd_hit & (reg_sel == REG_RESP);

    // Command FIFO (first-word-fall-through)
    logic [31:0]   cmd_mem [DEPTH];
    logic [AW-1:0] cmd_wr_ptr;
    logic [AW-1:0] cmd_rd_ptr;
    logic [LW-1:0] cmd_level;
    logic          cmd_full;
    logic          cmd_empty;
    logic          cmd_pop;
    logic          cmd_push;
    logic          ovf_evt;

    assign cmd_full  = (cmd_level == LW'(DEPTH));
    assign cmd_empty = (cmd_level == '0);
    // Both streams: a word moves on an edge exactly when valid and ready are
    // both high; valid never waits on ready, and ready comes from registers.
    assign cmd_pop   = ~cmd_empty & cmd_ready_i;
    assign cmd_push  = cmd_push_req & (~cmd_full | cmd_pop);
    assign ovf_evt   = cmd_push_req & cmd_full & ~cmd_pop;

    assign cmd_valid_o = ~cmd_empty;
    assign cmd_data_o  = cmd_empty ? 32'h0 : cmd_mem[cmd_rd_ptr];

    always_ff @(posedge wb_clk_i) begin
        if (cmd_push) begin
            cmd_mem[cmd_wr_ptr] <= wbs_dat_i;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_level  <= '0;
        end else if (flush) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            cmd_level  <= '0;
        end else begin
            if (cmd_push) begin
                cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
            end
            if (cmd_pop) begin
                cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
            end
            cmd_level <= cmd_level + LW'(cmd_push) - LW'(cmd_pop);
        end
    end

    // Response FIFO
    logic [31:0]   rsp_mem [DEPTH];
    logic [AW-1:0] rsp_wr_ptr;
    logic [AW-1:0] rsp_rd_ptr;
    logic [LW-1:0] rsp_level;
    logic          rsp_full;
    logic          rsp_empty;
    logic          rsp_push;
    logic          rsp_pop;
    logic          udf_evt;

    assign rsp_full    = (rsp_level == LW'(DEPTH));
    assign rsp_empty   = (rsp_level == '0);
    assign rsp_ready_o = ~rsp_full;
    assign rsp_push    = rsp_valid_i & ~rsp_full;
    assign rsp_pop     = resp_rd & ~rsp_empty;
    assign udf_evt     = resp_rd & rsp_empty;

    always_ff @(posedge wb_clk_i) begin
        if (rsp_push) begin
            rsp_mem[rsp_wr_ptr] <= rsp_data_i;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            rsp_level  <= '0;
        end else if (flush) begin
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            rsp_level  <= '0;
        end else begin
            if (rsp_push) begin
                rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
            end
            if (rsp_pop) begin
                rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
            end
            rsp_level <= rsp_level + LW'(rsp_push) - LW'(rsp_pop);
        end
    end

    // Sticky flags, interrupt enable and interrupt
    logic ovf;
    logic udf;
    logic irq_en;
    logic irq_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ovf    <= 1'b0;
            udf    <= 1'b0;
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (flag_clr) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end else begin
                if (ovf_evt) begin
                    ovf <= 1'b1;
                end
                if (udf_evt) begin
                    udf <= 1'b1;
                end
            end
            if (ctrl_wr) begin
                irq_en <= wbs_dat_i[2];
            end
            irq_q <= irq_en & (~rsp_empty | ovf | udf);
        end
    end

    assign irq_o = irq_q;

    // Read mux, evaluated on pre-update state
    logic [31:0] rdata;

    always_comb begin
        rdata = 32'h0;
        unique case (reg_sel)
            REG_CMD:    rdata = 32'h0;
            REG_STATUS: rdata = {10'h0, udf, ovf, rsp_empty, rsp_full, cmd_empty, cmd_full,
                                 8'(rsp_level), 8'(cmd_level)};
            REG_RESP:   rdata = rsp_empty ? 32'h0 : rsp_mem[rsp_rd_ptr];
            REG_CTRL:   rdata = {29'h0, irq_en, 2'b00};
            default:    rdata = 32'h0;
        endcase
    end

    // Registered ack; read data lives on the bus for the ack cycle only
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= 32'h0;
        end else begin
            ack_q <= hit;
            dat_q <= rd_hit ? rdata : 32'h0;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_wb_cmd_bridge.sv
// Self-checking bench for wb_cmd_bridge: directed scenarios plus randomized
// traffic checked cycle by cycle against a queue-based reference model.
module tb_wb_cmd_bridge;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'h0;
    logic [31:0] wbs_dat_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [31:0] cmd_data_o;
    logic        cmd_valid_o;
    logic        cmd_ready_i = 1'b0;
    logic [31:0] rsp_data_i = 32'h0;
    logic        rsp_valid_i = 1'b0;
    logic        rsp_ready_o;
    logic        irq_o;

    wb_cmd_bridge #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .cmd_data_o(cmd_data_o), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
        .rsp_data_i(rsp_data_i), .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
        .irq_o(irq_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int  total = 0;
    int  bad = 0;
    bit  mon_en = 1'b0;
    bit  rand_core = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: queues plus flags, stepped on every clock edge
    logic [31:0] m_cmd[$];
    logic [31:0] m_rsp[$];
    bit          m_ovf, m_udf, m_irq_en, m_ack, m_irq;
    logic [31:0] m_dat;

    task automatic model_step();
        bit          hit, we, full_sel, flush, irq_next, cpop, rpush;
        int          off;
        logic [31:0] rdv;
        irq_next = m_irq_en && (m_rsp.size() != 0 || m_ovf || m_udf);
        hit      = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE[31:4]) && !m_ack;
        we       = wbs_we_i;
        full_sel = (wbs_sel_i == 4'hF);
        off      = int'(wbs_adr_i[3:2]);
        flush    = hit && we && full_sel && off == 3 && wbs_dat_i[0];
        cpop     = m_cmd.size() != 0 && cmd_ready_i;
        rpush    = rsp_valid_i && m_rsp.size() < DEPTH;
        rdv      = 32'h0;
        if (hit && !we) begin
            if (off == 1) begin
                rdv = (32'(m_udf) << 21) | (32'(m_ovf) << 20)
                    | (32'(m_rsp.size() == 0) << 19) | (32'(m_rsp.size() == DEPTH) << 18)
                    | (32'(m_cmd.size() == 0) << 17) | (32'(m_cmd.size() == DEPTH) << 16)
                    | (32'(m_rsp.size()) << 8) | 32'(m_cmd.size());
            end else if (off == 2) begin
                if (m_rsp.size() == 0) m_udf = 1'b1;
                else rdv = m_rsp.pop_front();
            end else if (off == 3) begin
                rdv = {29'h0, m_irq_en, 2'b00};
            end
        end
        if (!flush && cpop) void'(m_cmd.pop_front());
        if (hit && we && full_sel && off == 0) begin
            if (m_cmd.size() < DEPTH) m_cmd.push_back(wbs_dat_i);
            else m_ovf = 1'b1;
        end
        if (!flush && rpush) m_rsp.push_back(rsp_data_i);
        if (flush) begin
            m_cmd.delete();
            m_rsp.delete();
        end
        if (hit && we && full_sel && off == 3) begin
            if (wbs_dat_i[1]) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            m_irq_en = wbs_dat_i[2];
        end
        m_ack = hit;
        m_dat = (hit && !we) ? rdv : 32'h0;
        m_irq = irq_next;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cmd.delete();
            m_rsp.delete();
            m_ovf = 0; m_udf = 0; m_irq_en = 0; m_ack = 0; m_irq = 0; m_dat = 32'h0;
        end else begin
            model_step();
        end
    end

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("mon_ack", 32'(wbs_ack_o), 32'(m_ack));
            check_eq("mon_dat", wbs_dat_o, m_dat);
            check_eq("mon_cmd_valid", 32'(cmd_valid_o), 32'(m_cmd.size() != 0));
            check_eq("mon_cmd_data", cmd_data_o, (m_cmd.size() != 0) ? m_cmd[0] : 32'h0);
            check_eq("mon_rsp_ready", 32'(rsp_ready_o), 32'(m_rsp.size() < DEPTH));
            check_eq("mon_irq", 32'(irq_o), 32'(m_irq));
        end
    end

    // Driver tasks
    task automatic cyc_wait();
        @(negedge clk);
        if (rand_core) begin
            cmd_ready_i = 1'($urandom_range(0, 1));
            rsp_valid_i = ($urandom_range(0, 2) == 0);
            rsp_data_i  = $urandom;
        end
    endtask

    task automatic wb_xfer(input logic [31:0] adr, input bit we, input logic [3:0] sel,
                           input logic [31:0] wdat, output logic [31:0] rdat, output bit acked);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = wdat;
        acked = 1'b0;
        rdat  = 32'h0;
        for (int i = 0; i < 4 && !acked; i++) begin
            cyc_wait();
            if (wbs_ack_o) begin
                acked = 1'b1;
                rdat  = wbs_dat_o;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wb_wr(input int off, input logic [31:0] d);
        logic [31:0] r;
        bit          a;
        wb_xfer(BASE + 32'(off * 4), 1'b1, 4'hF, d, r, a);
        check_eq("wr_ack", 32'(a), 32'd1);
    endtask

    task automatic wb_rd(input int off, output logic [31:0] d);
        bit a;
        wb_xfer(BASE + 32'(off * 4), 1'b0, 4'hF, 32'h0, d, a);
        check_eq("rd_ack", 32'(a), 32'd1);
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] rd_v;
    bit          acked;
    int          accepts;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        cyc_wait();

        // Reset state
        wb_rd(1, rd_v);
        check_eq("reset_status", rd_v, 32'h000A_0000);
        check_eq("reset_rsp_ready", 32'(rsp_ready_o), 32'd1);
        check_eq("reset_irq", 32'(irq_o), 32'd0);

        // Single command
        wb_wr(0, 32'hDEAD_BEEF);
        check_eq("cmd_valid_at_ack", 32'(cmd_valid_o), 32'd1);
        check_eq("cmd_data_at_ack", cmd_data_o, 32'hDEAD_BEEF);
        wb_rd(1, rd_v);
        check_eq("status_one_cmd", rd_v, 32'h0008_0001);
        cmd_ready_i = 1'b1;
        cyc_wait();
        cmd_ready_i = 1'b0;
        check_eq("cmd_drained", 32'(cmd_valid_o), 32'd0);

        // Overflow: 9 words into an 8-deep FIFO
        for (int i = 1; i <= 9; i++) wb_wr(0, 32'(i));
        wb_rd(1, rd_v);
        check_eq("status_ovf_full", rd_v, 32'h0019_0008);
        for (int i = 1; i <= 8; i++) exp_q.push_back(32'(i));
        cmd_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_valid_o) begin
                if (exp_q.size() == 0) check_eq("drain_extra", cmd_data_o, 32'hFFFF_FFFF);
                else check_eq("drain_word", cmd_data_o, exp_q.pop_front());
            end
            cyc_wait();
        end
        cmd_ready_i = 1'b0;
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);
        wb_wr(3, 32'h2);
        wb_rd(1, rd_v);
        check_eq("status_ovf_cleared", rd_v, 32'h000A_0000);

        // Responses, underflow and interrupt
        wb_wr(3, 32'h4);
        rsp_valid_i = 1'b1; rsp_data_i = 32'h11;
        cyc_wait();
        rsp_data_i = 32'h22;
        cyc_wait();
        rsp_valid_i = 1'b0;
        cyc_wait();
        check_eq("irq_on_rsp", 32'(irq_o), 32'd1);
        wb_rd(2, rd_v); check_eq("resp_0x11", rd_v, 32'h11);
        wb_rd(2, rd_v); check_eq("resp_0x22", rd_v, 32'h22);
        wb_rd(2, rd_v); check_eq("resp_empty", rd_v, 32'h0);
        wb_rd(1, rd_v); check_eq("status_udf", rd_v, 32'h002A_0000);
        cyc_wait();
        check_eq("irq_on_udf", 32'(irq_o), 32'd1);
        wb_wr(3, 32'h6);
        cyc_wait();
        check_eq("irq_cleared", 32'(irq_o), 32'd0);
        wb_rd(3, rd_v); check_eq("ctrl_readback", rd_v, 32'h4);

        // Response backpressure
        accepts = 0;
        rsp_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rsp_data_i = 32'h100 + 32'(accepts);
            if (rsp_ready_o) begin
                exp_q.push_back(rsp_data_i);
                accepts++;
            end
            cyc_wait();
        end
        rsp_valid_i = 1'b0;
        check_eq("rsp_accepts", 32'(accepts), 32'd8);
        check_eq("rsp_ready_full", 32'(rsp_ready_o), 32'd0);
        wb_rd(2, rd_v);
        check_eq("resp_first", rd_v, exp_q.pop_front());
        check_eq("rsp_ready_again", 32'(rsp_ready_o), 32'd1);
        rsp_valid_i = 1'b1; rsp_data_i = 32'h108;
        exp_q.push_back(32'h108);
        cyc_wait();
        rsp_valid_i = 1'b0;
        check_eq("rsp_ready_refull", 32'(rsp_ready_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            wb_rd(2, rd_v);
            check_eq("resp_seq", rd_v, exp_q.pop_front());
        end
        wb_wr(3, 32'h2);

        // Miss address and partial byte select
        wb_xfer(BASE + 32'h10, 1'b1, 4'hF, 32'h5555, rd_v, acked);
        check_eq("miss_no_ack", 32'(acked), 32'd0);
        wb_xfer(BASE, 1'b1, 4'h3, 32'h7777, rd_v, acked);
        check_eq("partial_sel_ack", 32'(acked), 32'd1);
        wb_rd(1, rd_v);
        check_eq("status_after_miss_sel", rd_v, 32'h000A_0000);

        // Reset in the middle of an access
        wb_wr(0, 32'hAAAA_0001);
        wb_wr(3, 32'h4);
        rsp_valid_i = 1'b1; rsp_data_i = 32'h33;
        cyc_wait();
        rsp_valid_i = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_sel_i = 4'hF; wbs_adr_i = BASE + 32'h8;
        @(posedge clk);
        #1;
        check_eq("ack_before_rst", 32'(wbs_ack_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("rst_ack", 32'(wbs_ack_o), 32'd0);
        check_eq("rst_dat", wbs_dat_o, 32'h0);
        check_eq("rst_cmd_valid", 32'(cmd_valid_o), 32'd0);
        check_eq("rst_cmd_data", cmd_data_o, 32'h0);
        check_eq("rst_rsp_ready", 32'(rsp_ready_o), 32'd1);
        check_eq("rst_irq", 32'(irq_o), 32'd0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        cyc_wait();
        rst = 1'b0;
        cyc_wait();
        wb_rd(1, rd_v);
        check_eq("status_after_rst", rd_v, 32'h000A_0000);
        wb_rd(3, rd_v);
        check_eq("ctrl_after_rst", rd_v, 32'h0);

        // Randomized traffic against the model
        rand_core = 1'b1;
        for (int n = 0; n < 500; n++) begin
            logic [31:0] adr, d;
            logic [3:0]  sel;
            int          off;
            off = $urandom_range(0, 3);
            adr = ($urandom_range(0, 9) == 0) ? BASE + 32'h10 + 32'(off * 4) : BASE + 32'(off * 4);
            sel = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
            d   = $urandom;
            if (off == 3) d = {29'h0, 1'($urandom_range(0, 1)),
                               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0)};
            wb_xfer(adr, 1'($urandom_range(0, 1)), sel, d, rd_v, acked);
            repeat ($urandom_range(0, 2)) cyc_wait();
        end
        rand_core = 1'b0;
        cmd_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
        cyc_wait();
        cyc_wait();
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
